uart_rx: RTL and testbench

//  Receives 8N1 asynchronous serial on rxd and presents each good byte on a valid/ready

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 16 +
 rtl/uart_rx_sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the 8N1 UART receiver: FSM state encoding,
// byte width and the clocks-per-bit derivation.
package uart_rx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte stream plus error pulses.
// Handshake: a byte transfers on a rising edge where valid & ready are both 1;
// once valid rises, data holds until that transfer and ready is ignored while valid is 0.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic [BYTE_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              frame_err;
  logic              overrun;

  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave  (input data, valid, frame_err, overrun, output ready);

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; flops reset to RST_VAL so an
// idle-high line does not look like an edge coming out of reset.
module sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled FSM centred on each bit, delivering good bytes
// on a valid/ready stream with frame-error and overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 96_000_000,
  parameter int unsigned BAUD          = 12_000_000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rxd,
  uart_rx_if.master rx_if,
  output state_e    state_o
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQUENCY, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TICK_W       = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  if (CLKS_PER_BIT < 4) begin : g_cfg_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic rx_s;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rxd),
    .q_o   (rx_s)
  );

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                fe_q, fe_d;
  logic                ov_q, ov_d;
  logic                good_stop;
  logic                bad_stop;
  logic                tick_zero;

  assign tick_zero = (tick_q == '0);

  // Each sample point fires when tick reaches zero; the counter is reloaded
  // on the same cycle so the next sample lands one bit period later.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          tick_d  = TICK_HALF;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!tick_zero) begin
          tick_d = tick_q - TICK_ONE;
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          bit_d   = 3'd0;
          tick_d  = TICK_FULL;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!tick_zero) begin
          tick_d = tick_q - TICK_ONE;
        end else begin
          shreg_d = {rx_s, shreg_q[BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
          tick_d  = TICK_FULL;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick_zero) begin
          tick_d = tick_q - TICK_ONE;
        end else if (rx_s) begin
          good_stop = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          bad_stop  = 1'b1;
          state_d   = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completing byte wins over a same-cycle consume; a byte arriving while
  // the previous one is still held is dropped and flagged.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = bad_stop;
    ov_d    = 1'b0;
    if (valid_q && rx_if.ready) valid_d = 1'b0;
    if (good_stop) begin
      if (!valid_q || rx_if.ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.frame_err = fe_q;
  assign rx_if.overrun   = ov_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx against a byte-queue model of the
// serial line, including latency, baud skew, glitches, framing, overrun and reset.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CLK_T = 100;
  localparam int BIT_T = 8 * CLK_T;
  localparam int FAST_T = 776;
  localparam int SLOW_T = 824;

  logic   clk = 1'b0;
  logic   reset;
  logic   rxd;
  state_e state;

  uart_rx_if rx_if ();

  uart_rx #(.CLK_FREQUENCY(96_000_000), .BAUD(12_000_000)) dut (
    .clk     (clk),
    .reset   (reset),
    .rxd     (rxd),
    .rx_if   (rx_if),
    .state_o (state)
  );

  always #(CLK_T / 2) clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted byte must be the oldest one sent on the line.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_if.frame_err) fe_cnt++;
      if (rx_if.overrun) ov_cnt++;
      if (rx_if.frame_err || rx_if.overrun)
        check("fe_ov_exclusive", 32'(rx_if.frame_err & rx_if.overrun), 32'd0);
      if (rx_if.valid && rx_if.ready) begin
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("byte_data", 32'(rx_if.data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_val);
    rxd = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_t);
    end
    rxd = stop_val;
    #(bit_t);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bit_t);
    exp_q.push_back(b);
    send_frame(b, bit_t, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    #(n * BIT_T);
  endtask

  initial begin
    #(CLK_T * 60000);
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  initial begin
    int n;
    int fe0;
    int ov0;
    int exp_fe;
    logic [7:0] b;
    logic [7:0] c3;
    int skew;
    int gap;

    rxd = 1'b1;
    reset = 1'b1;
    rx_if.ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_if.valid), 32'd0);
    check("rst_data", 32'(rx_if.data), 32'h00);
    check("rst_frame_err", 32'(rx_if.frame_err), 32'd0);
    check("rst_overrun", 32'(rx_if.overrun), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Nominal byte: valid must appear 2 sync cycles + 77 cycles after the pin falls.
    @(posedge clk);
    #1;
    n = 0;
    fork
      send_byte(8'hA5, BIT_T);
      begin
        for (int k = 0; k < 200; k++) begin
          @(posedge clk);
          n++;
          #1;
          if (rx_if.valid) break;
        end
        check("t1_latency", 32'(n), 32'd79);
        check("t1_data", 32'(rx_if.data), 32'hA5);
        @(posedge clk);
        #1;
        check("t1_valid_one_cycle", 32'(rx_if.valid), 32'd0);
      end
    join
    idle_bits(2);

    // Back-to-back bytes at both skew extremes.
    for (int s = 0; s < 2; s++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      skew = (s == 0) ? SLOW_T : FAST_T;
      send_byte(8'h00, skew);
      send_byte(8'hFF, skew);
      send_byte(8'h55, skew);
      idle_bits(2);
      check("t2_all_received", 32'(exp_q.size()), 32'd0);
      check("t2_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
      check("t2_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    end

    // Short low glitch is rejected at the start-bit centre.
    @(posedge clk);
    #1;
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd = 1'b1;
    idle_bits(2);
    check("t3_state_idle", 32'(state), 32'(ST_IDLE));
    check("t3_no_valid", 32'(rx_if.valid), 32'd0);
    send_byte(8'h3C, BIT_T);
    idle_bits(2);
    check("t3_recovered", 32'(exp_q.size()), 32'd0);

    // Bad stop bit followed by a long break.
    fe0 = fe_cnt;
    send_frame(8'h81, BIT_T, 1'b0);
    #(20 * BIT_T);
    check("t4_one_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("t4_wait_high", 32'(state), 32'(ST_WAIT_HIGH));
    check("t4_no_valid", 32'(rx_if.valid), 32'd0);
    idle_bits(2);
    check("t4_back_idle", 32'(state), 32'(ST_IDLE));
    send_byte(8'h42, BIT_T);
    idle_bits(2);
    check("t4_recovered", 32'(exp_q.size()), 32'd0);
    check("t4_single_frame_err", 32'(fe_cnt - fe0), 32'd1);

    // Consumer stalled: second byte is dropped with an overrun pulse.
    ov0 = ov_cnt;
    rx_if.ready = 1'b0;
    send_byte(8'h11, BIT_T);
    send_frame(8'h22, BIT_T, 1'b1);
    idle_bits(2);
    check("t5_valid_held", 32'(rx_if.valid), 32'd1);
    check("t5_data_held", 32'(rx_if.data), 32'h11);
    check("t5_one_overrun", 32'(ov_cnt - ov0), 32'd1);
    @(posedge clk);
    #1;
    rx_if.ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_valid_dropped", 32'(rx_if.valid), 32'd0);
    check("t5_consumed", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of bit 4 discards the partial byte.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    c3 = 8'hC3;
    rxd = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rxd = c3[i];
      #(BIT_T);
    end
    rxd = c3[4];
    #(BIT_T / 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_rst_valid", 32'(rx_if.valid), 32'd0);
    check("t6_rst_state", 32'(state), 32'(ST_IDLE));
    reset = 1'b0;
    idle_bits(12);
    check("t6_idle_after_rst", 32'(state), 32'(ST_IDLE));
    send_byte(8'h7E, BIT_T);
    idle_bits(2);
    check("t6_only_new_byte", 32'(exp_q.size()), 32'd0);
    check("t6_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // Random bytes, random skew within +/-3%, random gaps, occasional bad stop.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_fe = 0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      skew = int'($urandom_range(FAST_T, SLOW_T));
      if ($urandom_range(0, 5) == 0) begin
        send_frame(b, skew, 1'b0);
        exp_fe++;
        idle_bits(2);
      end else begin
        send_byte(b, skew);
        gap = int'($urandom_range(0, 2));
        rxd = 1'b1;
        #(gap * skew);
      end
    end
    idle_bits(2);
    check("t7_all_received", 32'(exp_q.size()), 32'd0);
    check("t7_frame_err_count", 32'(fe_cnt - fe0), 32'(exp_fe));
    check("t7_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
